// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide issue path.
// Arbiter FSM states and the ALUOp codes understood by the unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    RESP
  } arb_state_t;

  localparam logic [4:0] ALU_MULT  = 5'h18;
  localparam logic [4:0] ALU_MULTU = 5'h19;
  localparam logic [4:0] ALU_DIV   = 5'h1a;
  localparam logic [4:0] ALU_DIVU  = 5'h1b;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant for the shared mult/div unit.
// last_q=1 after reset, so slot 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11)
        gnt_o = last_q ? 2'b01 : 2'b10;
      else
        gnt_o = req_i;
    end
  end

  assign last_d = (|gnt_o) ? gnt_o[1] : last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/muldiv_issue_arbiter.sv
// Shares one mult/div unit between the two EXE issue slots.
// Grant, operand capture, start pulse, completion wait, flush drain.
module muldiv_issue_arbiter
  import muldiv_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [1:0]          req_valid,
  input  logic [2*OP_W-1:0]   req_op,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic [1:0]          req_ready,
  output logic                unit_start,
  output logic [OP_W-1:0]     unit_op,
  output logic [DATA_W-1:0]   unit_a,
  output logic [DATA_W-1:0]   unit_b,
  input  logic                unit_done,
  input  logic [DATA_W-1:0]   unit_hi,
  input  logic [DATA_W-1:0]   unit_lo,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_hi,
  output logic [DATA_W-1:0]   rsp_lo,
  output logic                busy,
  output logic                timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t          state_q, state_d;
  logic [1:0]          gnt;
  logic                arb_en;
  logic                timed_out;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   a_q, b_q, hi_q, lo_q;
  logic                id_q;

  assign arb_en    = (state_q == IDLE) && !flush;
  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (arb_en),
    .req_i (req_valid),
    .gnt_o (gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (|gnt) state_d = ISSUE;
      ISSUE: state_d = flush ? IDLE : WAIT;
      WAIT: begin
        if (unit_done)      state_d = flush ? IDLE : RESP;
        else if (flush)     state_d = DRAIN;
        else if (timed_out) state_d = IDLE;
      end
      DRAIN: if (unit_done || timed_out) state_d = IDLE;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Watchdog restarts on every entry into WAIT or DRAIN
  always_comb begin
    cnt_d = '0;
    if ((state_d == WAIT || state_d == DRAIN) && state_d == state_q)
      cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    req_ready   = gnt;
    unit_start  = (state_q == ISSUE) && !flush;
    rsp_valid   = (state_q == RESP) && !flush;
    busy        = (state_q != IDLE);
    timeout_err = timed_out && !unit_done &&
                  ((state_q == WAIT && !flush) || state_q == DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (|gnt) begin
        op_q <= gnt[1] ? req_op[2*OP_W-1:OP_W]   : req_op[OP_W-1:0];
        a_q  <= gnt[1] ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
        b_q  <= gnt[1] ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
        id_q <= gnt[1];
      end
      if (state_q == WAIT && unit_done && !flush) begin
        hi_q <= unit_hi;
        lo_q <= unit_lo;
      end
    end
  end

  assign unit_op = op_q;
  assign unit_a  = a_q;
  assign unit_b  = b_q;
  assign rsp_id  = id_q;
  assign rsp_hi  = hi_q;
  assign rsp_lo  = lo_q;

endmodule

// File: tb/tb_muldiv_issue_arbiter.sv
// Scoreboard bench for muldiv_issue_arbiter.
// Second instance with TIMEOUT=8 covers the watchdog.
module tb_muldiv_issue_arbiter;
  import muldiv_pkg::*;

  localparam int DW = 32;
  localparam int OW = 5;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst, flush, unit_done;
  logic [1:0] req_valid;
  logic [2*OW-1:0] req_op;
  logic [2*DW-1:0] req_a, req_b;
  logic [DW-1:0] unit_hi, unit_lo;

  logic [1:0] req_ready, req_ready8;
  logic unit_start, unit_start8;
  logic [OW-1:0] unit_op, unit_op8;
  logic [DW-1:0] unit_a, unit_b, unit_a8, unit_b8;
  logic rsp_valid, rsp_id, rsp_valid8, rsp_id8;
  logic [DW-1:0] rsp_hi, rsp_lo, rsp_hi8, rsp_lo8;
  logic busy, timeout_err, busy8, timeout_err8;

  int total = 0;
  int bad = 0;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  muldiv_issue_arbiter #(.DATA_W(DW), .OP_W(OW), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .unit_start(unit_start), .unit_op(unit_op),
    .unit_a(unit_a), .unit_b(unit_b), .unit_done(unit_done),
    .unit_hi(unit_hi), .unit_lo(unit_lo), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .busy(busy), .timeout_err(timeout_err)
  );

  muldiv_issue_arbiter #(.DATA_W(DW), .OP_W(OW), .TIMEOUT(8)) dut8 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready8), .unit_start(unit_start8), .unit_op(unit_op8),
    .unit_a(unit_a8), .unit_b(unit_b8), .unit_done(unit_done),
    .unit_hi(unit_hi), .unit_lo(unit_lo), .rsp_valid(rsp_valid8),
    .rsp_id(rsp_id8), .rsp_hi(rsp_hi8), .rsp_lo(rsp_lo8),
    .busy(busy8), .timeout_err(timeout_err8)
  );

  // Monitor: every result pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rsp_valid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected got id=%0d hi=%0h lo=%0h exp=none",
                 rsp_id, rsp_hi, rsp_lo);
      end else begin
        mon_e = q.pop_front();
        if ({rsp_id, rsp_hi, rsp_lo} !== {mon_e.id, mon_e.hi, mon_e.lo}) begin
          bad++;
          $display("FAIL rsp_data got id=%0d hi=%0h lo=%0h exp id=%0d hi=%0h lo=%0h",
                   rsp_id, rsp_hi, rsp_lo, mon_e.id, mon_e.hi, mon_e.lo);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    settle();
  endtask

  // Called in the handshake cycle; runs ISSUE, WAIT (dly idle cycles), RESP
  task automatic finish_op(input logic id, input logic [OW-1:0] eop,
                           input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                           input int dly, input logic [DW-1:0] hi,
                           input logic [DW-1:0] lo);
    cyc();
    req_valid = 2'b00;
    settle();
    chk("start", {63'd0, unit_start}, 64'd1);
    chk("unit_op", {59'd0, unit_op}, {59'd0, eop});
    chk("unit_a", {32'd0, unit_a}, {32'd0, ea});
    chk("unit_b", {32'd0, unit_b}, {32'd0, eb});
    cyc();
    settle();
    chk("start_off", {63'd0, unit_start}, 64'd0);
    repeat (dly) cyc();
    q.push_back(exp_t'{id: id, hi: hi, lo: lo});
    unit_done = 1'b1;
    unit_hi = hi;
    unit_lo = lo;
    cyc();
    unit_done = 1'b0;
    unit_hi = '0;
    unit_lo = '0;
    settle();
    chk("rsp_pulse", {63'd0, rsp_valid}, 64'd1);
    cyc();
    settle();
    chk("idle_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic do_op(input logic [1:0] vld, input logic [1:0] eg,
                       input logic [OW-1:0] op0, input logic [OW-1:0] op1,
                       input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                       input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                       input int dly, input logic [DW-1:0] hi,
                       input logic [DW-1:0] lo);
    req_valid = vld;
    req_op = {op1, op0};
    req_a = {a1, a0};
    req_b = {b1, b0};
    settle();
    chk("grant", {62'd0, req_ready}, {62'd0, eg});
    finish_op(eg[1], eg[1] ? op1 : op0, eg[1] ? a1 : a0, eg[1] ? b1 : b0,
              dly, hi, lo);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    unit_done = 1'b0;
    req_valid = 2'b00;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    unit_hi = '0;
    unit_lo = '0;
    do_reset();

    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {62'd0, req_ready}, 64'd0);
    chk("rst_start", {63'd0, unit_start}, 64'd0);
    chk("rst_rsp", {63'd0, rsp_valid}, 64'd0);
    chk("rst_to", {63'd0, timeout_err}, 64'd0);
    chk("rst_a", {32'd0, unit_a}, 64'd0);

    // 1: slot0 MULT 3*5, done 4 cycles after start
    do_op(2'b01, 2'b01, ALU_MULT, ALU_DIV, 32'd3, 32'd5, 32'd9, 32'd9,
          3, 32'd0, 32'd15);

    // 2: tie twice from reset -> slot0 then slot1; singles immediate
    do_reset();
    do_op(2'b11, 2'b01, ALU_MULTU, ALU_DIV, 32'h11, 32'h22, 32'h33, 32'h44,
          0, 32'h1, 32'h2);
    do_op(2'b11, 2'b10, ALU_MULTU, ALU_DIV, 32'h11, 32'h22, 32'h33, 32'h44,
          2, 32'hA, 32'hB);
    do_op(2'b10, 2'b10, ALU_MULT, ALU_DIVU, 32'h5, 32'h6, 32'h70, 32'h7,
          1, 32'h0, 32'h10);
    do_op(2'b01, 2'b01, ALU_DIV, ALU_DIVU, 32'd100, 32'd7, 32'h1, 32'h1,
          5, 32'd2, 32'd14);

    // 3: flush in WAIT, done 10 cycles later -> drained silently
    req_valid = 2'b01;
    req_op = {ALU_MULT, ALU_DIV};
    req_a = {32'h0, 32'h50};
    req_b = {32'h0, 32'h60};
    settle();
    chk("f3_grant", {62'd0, req_ready}, 64'd1);
    cyc();
    req_valid = 2'b00;
    cyc();
    flush = 1'b1;
    settle();
    chk("f3_norsp", {63'd0, rsp_valid}, 64'd0);
    cyc();
    flush = 1'b0;
    req_valid = 2'b01;
    for (int i = 0; i < 9; i++) begin
      settle();
      chk("drain_ready", {62'd0, req_ready}, 64'd0);
      chk("drain_busy", {63'd0, busy}, 64'd1);
      cyc();
    end
    unit_done = 1'b1;
    unit_lo = 32'hDEAD;
    settle();
    chk("drain_done_ready", {62'd0, req_ready}, 64'd0);
    cyc();
    unit_done = 1'b0;
    unit_lo = '0;
    settle();
    chk("post_drain_grant", {62'd0, req_ready}, 64'd1);
    finish_op(1'b0, ALU_DIV, 32'h50, 32'h60, 0, 32'h3, 32'h4);

    // 4: flush in ISSUE -> no start, back to IDLE, then a normal op
    req_valid = 2'b01;
    settle();
    chk("f4_grant", {62'd0, req_ready}, 64'd1);
    cyc();
    req_valid = 2'b00;
    flush = 1'b1;
    settle();
    chk("f4_nostart", {63'd0, unit_start}, 64'd0);
    cyc();
    flush = 1'b0;
    settle();
    chk("f4_idle", {63'd0, busy}, 64'd0);
    do_op(2'b10, 2'b10, ALU_MULT, ALU_MULTU, 32'h1, 32'h1, 32'hFFFF_FFFF,
          32'h2, 1, 32'h1, 32'hFFFF_FFFE);

    // 5: TIMEOUT=8 instance, unit never completes
    do_reset();
    req_valid = 2'b01;
    req_a = {32'h0, 32'h7};
    settle();
    chk("to_grant", {62'd0, req_ready8}, 64'd1);
    cyc();
    req_valid = 2'b00;
    cyc();
    for (int k = 0; k < 7; k++) begin
      settle();
      chk("to_early", {63'd0, timeout_err8}, 64'd0);
      cyc();
    end
    settle();
    chk("to_pulse", {63'd0, timeout_err8}, 64'd1);
    chk("to_norsp", {63'd0, rsp_valid8}, 64'd0);
    cyc();
    settle();
    chk("to_idle", {63'd0, busy8}, 64'd0);
    chk("to_off", {63'd0, timeout_err8}, 64'd0);
    do_reset();

    // 6: async reset in WAIT, then a stray done
    req_valid = 2'b10;
    req_a = {32'h99, 32'h0};
    settle();
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("ar_busy", {63'd0, busy}, 64'd0);
    chk("ar_a", {32'd0, unit_a}, 64'd0);
    #1;
    rst = 1'b0;
    cyc();
    unit_done = 1'b1;
    unit_lo = 32'hBAD;
    settle();
    chk("stray_rsp", {63'd0, rsp_valid}, 64'd0);
    cyc();
    unit_done = 1'b0;
    unit_lo = '0;
    settle();
    chk("stray_rsp2", {63'd0, rsp_valid}, 64'd0);
    chk("stray_busy", {63'd0, busy}, 64'd0);
    do_op(2'b11, 2'b01, ALU_MULT, ALU_MULT, 32'h2, 32'h3, 32'h4, 32'h5,
          0, 32'h0, 32'h6);

    cyc();
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
